cl_cc_trigger_sequencer: RTL and testbench
==========================================

// Module: cl_cc_trigger_sequencer
// PURPOSE
//  Drives the four Camera Link camera-control lines (CL_CC) in the CL_clk domain.
//  CC[0] carries a sequenced exposure-trigger pulse train; CC[3:1] carry static levels.
//  Modes: single/burst of N pulses, or continuous free-run. Programmable delay, width and period.
//  Config/strobe inputs come from the AXI register block, already synchronised to CL_clk.
// PARAMETERS
//  CNT_WIDTH  24  width of delay/width/period counters (CL_clk cycles)
//  NUM_WIDTH  16  width of burst count and pulse counter
// PORTS
//  CL_clk         in   1          camera-link clock; all logic on rising edge
//  CL_CC_aresetn  in   1          asynchronous, active-low reset
//  cfg_enable     in   1          sequencer enable; deassert = abort
//  cfg_mode       in   1          0 = burst of cfg_count pulses, 1 = continuous
//  cfg_delay      in   CNT_WIDTH  cycles from accepted start to first pulse rise
//  cfg_width      in   CNT_WIDTH  pulse high time (0 treated as 1)
//  cfg_period     in   CNT_WIDTH  rise-to-rise time
//  cfg_count      in   NUM_WIDTH  pulses per burst (0 treated as 1)
//  cfg_polarity   in   1          1 = invert CC[0] (active-low trigger)
//  cfg_cc_static  in   3          levels for CC[3:1]
//  start          in   1          one-cycle start strobe
//  abort          in   1          one-cycle abort strobe
//  CL_CC          out  4          camera-control lines, registered
//  busy           out  1          high in any state other than IDLE
//  done           out  1          one-cycle pulse on normal burst completion
//  pulse_cnt      out  NUM_WIDTH  pulses issued since last accepted start
// BEHAVIOUR
//  - Reset: state IDLE, CL_CC=4'b0000, busy=0, done=0, pulse_cnt=0, counters 0.
//  - Outputs are registered: CC[3:1]=cfg_cc_static, CC[0]=pulse^cfg_polarity, both 1 cycle after input/state.
//  - FSM states: IDLE, DELAY, HIGH, LOW. pulse=1 only in HIGH.
//  - IDLE: start & cfg_enable & !abort -> latch delay/width/period/count/mode;
//    pulse_cnt<=0; go to DELAY if delay>0, else HIGH. start while busy is ignored.
//  - DELAY: lasts exactly cfg_delay cycles -> HIGH.
//  - Entering HIGH increments pulse_cnt (NUM_WIDTH wrap allowed in continuous mode).
//  - HIGH: lasts W = max(cfg_width,1) cycles -> LOW.
//  - LOW: lasts L = max(period-W,1) cycles. Effective period = max(P, W+1).
//    Subtraction is unsigned at CNT_WIDTH; underflow is prevented by the max rule.
//  - End of LOW: continuous -> HIGH. Burst with pulse_cnt < count -> HIGH.
//    Otherwise -> IDLE with done=1 for exactly one cycle.
//  - Latency: start sampled in cycle t, delay 0 -> state HIGH at t+1, CC[0] active at t+2.
//  - abort=1 or cfg_enable=0 in any non-IDLE state: next state IDLE, no done pulse,
//    pulse_cnt frozen. abort wins over start in the same cycle.
//  - Latched config is not affected by cfg_* changes mid-sequence. Exceptions:
//    cfg_polarity and cfg_cc_static, which are live.
//  - Async reset mid-sequence: immediate return to reset values; restart needs a new start.
// TESTING
//  1. Reset with polarity=1 -> CL_CC=0 during reset; CC[0]=1, busy=0 two cycles after release.
//  2. Burst: delay=0, width=3, period=10, count=4, start -> 4 pulses of 3 high / 7 low;
//     pulse_cnt=4; done one cycle after last LOW; busy=0.
//  3. Edge cases: width=0, period=0, count=0, delay=5 -> first rise 5 cycles after start;
//     single 1-cycle pulse then 1 LOW cycle; done; pulse_cnt=1.
//  4. Continuous: width=2, period=4; abort after 3rd rise -> CC[0] inactive within 2 cycles;
//     no done; pulse_cnt=3.
//  5. start during busy and start+abort together -> both ignored; new start after done
//     restarts with pulse_cnt=0.
//  6. Mid-burst change of cfg_period to 100 -> old period kept. cfg_cc_static=3'b101 ->
//     CC[3:1]=101 next cycle.

Source files
------------

// File: rtl/cl_cc_trigger_sequencer.sv
// Camera Link CC line driver: CC[0] carries a delayed, programmable exposure pulse train
// (burst or continuous); CC[3:1] carry static levels. Single clock domain (CL_clk).
module cl_cc_trigger_sequencer #(
    parameter int CNT_WIDTH = 24,
    parameter int NUM_WIDTH = 16
) (
    input  logic                 CL_clk,
    input  logic                 CL_CC_aresetn,
    input  logic                 cfg_enable,
    input  logic                 cfg_mode,
    input  logic [CNT_WIDTH-1:0] cfg_delay,
    input  logic [CNT_WIDTH-1:0] cfg_width,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [NUM_WIDTH-1:0] cfg_count,
    input  logic                 cfg_polarity,
    input  logic [2:0]           cfg_cc_static,
    input  logic                 start,
    input  logic                 abort,
    output logic [3:0]           CL_CC,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_WIDTH-1:0] pulse_cnt
);

    typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [NUM_WIDTH-1:0] NUM_ONE = NUM_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] delay_q, width_q, low_q;
    logic [NUM_WIDTH-1:0] count_q;
    logic                 mode_q;
    logic [NUM_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
    logic                 done_q, done_d;
    logic                 latch;
    logic [3:0]           cc_q;

    // Zero width/count are promoted to 1; LOW time is clamped so the period is at least W+1.
    logic [CNT_WIDTH-1:0] width_eff, low_eff;
    logic [NUM_WIDTH-1:0] count_eff;

    assign width_eff = (cfg_width == '0) ? CNT_ONE : cfg_width;
    assign low_eff   = (cfg_period > width_eff) ? (cfg_period - width_eff) : CNT_ONE;
    assign count_eff = (cfg_count == '0) ? NUM_ONE : cfg_count;

    // NOTE: every signal driven here gets a default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_ONE;
        pulse_cnt_d = pulse_cnt_q;
        done_d      = 1'b0;
        latch       = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start && cfg_enable && !abort) begin
                    latch       = 1'b1;
                    pulse_cnt_d = '0;
                    if (cfg_delay != '0) begin
                        state_d = DELAY;
                    end else begin
                        state_d     = HIGH;
                        pulse_cnt_d = NUM_ONE;
                    end
                end
            end
            DELAY: begin
                if (cnt_q == delay_q - CNT_ONE) begin
                    state_d     = HIGH;
                    cnt_d       = '0;
                    pulse_cnt_d = pulse_cnt_q + NUM_ONE;
                end
            end
            HIGH: begin
                if (cnt_q == width_q - CNT_ONE) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            end
            LOW: begin
                if (cnt_q == low_q - CNT_ONE) begin
                    cnt_d = '0;
                    if (mode_q || (pulse_cnt_q < count_q)) begin
                        state_d     = HIGH;
                        pulse_cnt_d = pulse_cnt_q + NUM_ONE;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort (strobe or enable drop) overrides any transition and suppresses done.
        if ((state_q != IDLE) && (abort || !cfg_enable)) begin
            state_d     = IDLE;
            cnt_d       = '0;
            pulse_cnt_d = pulse_cnt_q;
            done_d      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CL_clk or negedge CL_CC_aresetn) begin
        if (!CL_CC_aresetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pulse_cnt_q <= '0;
            done_q      <= 1'b0;
            cc_q        <= '0;
            delay_q     <= '0;
            width_q     <= '0;
            low_q       <= '0;
            count_q     <= '0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            done_q      <= done_d;
            cc_q        <= {cfg_cc_static, (state_q == HIGH) ^ cfg_polarity};
            if (latch) begin
                delay_q <= cfg_delay;
                width_q <= width_eff;
                low_q   <= low_eff;
                count_q <= count_eff;
                mode_q  <= cfg_mode;
            end
        end
    end

    assign CL_CC     = cc_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_cl_cc_trigger_sequencer.sv
// Bench for cl_cc_trigger_sequencer: directed and random sequences checked cycle by cycle
// against a timeline model derived from delay/width/period/count arithmetic.
module tb_cl_cc_trigger_sequencer;

    localparam int CNT_WIDTH = 24;
    localparam int NUM_WIDTH = 16;

    logic                 CL_clk = 1'b0;
    logic                 CL_CC_aresetn;
    logic                 cfg_enable;
    logic                 cfg_mode;
    logic [CNT_WIDTH-1:0] cfg_delay;
    logic [CNT_WIDTH-1:0] cfg_width;
    logic [CNT_WIDTH-1:0] cfg_period;
    logic [NUM_WIDTH-1:0] cfg_count;
    logic                 cfg_polarity;
    logic [2:0]           cfg_cc_static;
    logic                 start;
    logic                 abort;
    logic [3:0]           CL_CC;
    logic                 busy;
    logic                 done;
    logic [NUM_WIDTH-1:0] pulse_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int last_pc = 0;

    cl_cc_trigger_sequencer #(.CNT_WIDTH(CNT_WIDTH), .NUM_WIDTH(NUM_WIDTH)) dut (
        .CL_clk        (CL_clk),
        .CL_CC_aresetn (CL_CC_aresetn),
        .cfg_enable    (cfg_enable),
        .cfg_mode      (cfg_mode),
        .cfg_delay     (cfg_delay),
        .cfg_width     (cfg_width),
        .cfg_period    (cfg_period),
        .cfg_count     (cfg_count),
        .cfg_polarity  (cfg_polarity),
        .cfg_cc_static (cfg_cc_static),
        .start         (start),
        .abort         (abort),
        .CL_CC         (CL_CC),
        .busy          (busy),
        .done          (done),
        .pulse_cnt     (pulse_cnt)
    );

    always #5 CL_clk = ~CL_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Timeline model. k counts rising edges with edge 1 sampling the start strobe; ab > 0
    // is the edge at which an abort is sampled. Pulse j (from 0) is high for edges
    // 1+d+j*P .. 1+d+j*P+W-1 with P = max(p, W+1).
    function automatic int m_hi(int k, int d, int W, int P, int N, bit cont, int ab);
        int idx;
        if (k < 1 || (ab > 0 && k >= ab)) return 0;
        idx = k - 1 - d;
        if (idx < 0) return 0;
        if (!cont && idx / P >= N) return 0;
        return (idx % P < W) ? 1 : 0;
    endfunction

    function automatic int m_busy(int k, int d, int P, int N, bit cont, int ab);
        if (k < 1 || (ab > 0 && k >= ab)) return 0;
        return (cont || k < 1 + d + N * P) ? 1 : 0;
    endfunction

    function automatic int m_done(int k, int d, int P, int N, bit cont, int ab);
        if (cont || (ab > 0 && k >= ab)) return 0;
        return (k == 1 + d + N * P) ? 1 : 0;
    endfunction

    function automatic int m_pc(int k, int d, int P, int N, bit cont, int ab);
        int kk;
        int idx;
        int v;
        kk = (ab > 0 && k >= ab) ? ab - 1 : k;
        if (kk < 1) return 0;
        idx = kk - 1 - d;
        if (idx < 0) return 0;
        v = idx / P + 1;
        if (!cont && v > N) v = N;
        return v % (1 << NUM_WIDTH);
    endfunction

    // Runs one sequence from a negedge in IDLE. ab_k: abort edge (0 = none), ab_en selects
    // enable-drop instead of the abort strobe; bs_k: start re-issued while busy;
    // cc_k: edge after which cfg_cc_static changes; scr scrambles latched cfg mid-run.
    task automatic run_seq(input int d, input int w, input int p, input int n,
                           input bit mode, input bit pol, input logic [2:0] stat,
                           input int ab_k, input bit ab_en, input int bs_k,
                           input int cc_k, input bit scr);
        int W;
        int P;
        int N;
        int ncyc;
        logic [2:0] st_prev;
        W = (w == 0) ? 1 : w;
        P = (p > W) ? p : W + 1;
        N = (n == 0) ? 1 : n;
        ncyc = (ab_k > 0) ? ab_k + 3 : 1 + d + N * P + 2;

        cfg_delay     = CNT_WIDTH'(d);
        cfg_width     = CNT_WIDTH'(w);
        cfg_period    = CNT_WIDTH'(p);
        cfg_count     = NUM_WIDTH'(n);
        cfg_mode      = mode;
        cfg_polarity  = pol;
        cfg_cc_static = stat;
        cfg_enable    = 1'b1;
        abort         = 1'b0;
        start         = 1'b1;

        for (int k = 1; k <= ncyc; k++) begin
            st_prev = cfg_cc_static;
            @(posedge CL_clk);
            @(negedge CL_clk);
            chk($sformatf("cc k=%0d", k), 32'(CL_CC),
                {28'd0, st_prev, 1'(m_hi(k - 1, d, W, P, N, mode, ab_k)) ^ pol});
            chk($sformatf("busy k=%0d", k), 32'(busy), m_busy(k, d, P, N, mode, ab_k));
            chk($sformatf("done k=%0d", k), 32'(done), m_done(k, d, P, N, mode, ab_k));
            chk($sformatf("pulse_cnt k=%0d", k), 32'(pulse_cnt),
                m_pc(k, d, P, N, mode, ab_k));

            start      = (k == bs_k && m_busy(k, d, P, N, mode, ab_k) != 0);
            abort      = (!ab_en && k + 1 == ab_k);
            cfg_enable = !(ab_en && k + 1 == ab_k);
            if (k == cc_k) cfg_cc_static = 3'($urandom);
            if (scr && k == 2) begin
                cfg_delay  = CNT_WIDTH'($urandom_range(0, 200));
                cfg_width  = CNT_WIDTH'($urandom_range(0, 200));
                cfg_period = 24'd100;
                cfg_count  = NUM_WIDTH'($urandom_range(0, 200));
                cfg_mode   = ~mode;
            end
        end
        start      = 1'b0;
        abort      = 1'b0;
        cfg_enable = 1'b1;
        last_pc    = m_pc(ncyc, d, P, N, mode, ab_k);
    endtask

    initial begin
        int d;
        int w;
        int p;
        int n;
        int W;
        int P;
        int N;
        int end_k;
        int ab_k;
        bit mode;

        // Reset with active-low trigger polarity
        CL_CC_aresetn = 1'b0;
        cfg_enable    = 1'b1;
        cfg_mode      = 1'b0;
        cfg_delay     = '0;
        cfg_width     = '0;
        cfg_period    = '0;
        cfg_count     = '0;
        cfg_polarity  = 1'b1;
        cfg_cc_static = 3'b000;
        start         = 1'b0;
        abort         = 1'b0;
        repeat (3) @(negedge CL_clk);
        chk("reset cc", 32'(CL_CC), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset pulse_cnt", 32'(pulse_cnt), 32'h0);
        CL_CC_aresetn = 1'b1;
        repeat (2) @(negedge CL_clk);
        chk("post-reset cc", 32'(CL_CC), 32'h1);
        chk("post-reset busy", 32'(busy), 32'h0);

        // Burst of 4 (3 high / 7 low), start re-issued while busy, period change mid-burst
        run_seq(0, 3, 10, 4, 1'b0, 1'b0, 3'b010, 0, 1'b0, 5, 0, 1'b1);
        // Restart after done; zero width/period/count with delay 5; live CC[3:1] change
        run_seq(5, 0, 0, 0, 1'b0, 1'b1, 3'b000, 0, 1'b0, 0, 3, 1'b0);
        // Continuous width 2 period 4, aborted right after the third rise (edge 9)
        run_seq(0, 2, 4, 0, 1'b1, 1'b0, 3'b101, 10, 1'b0, 4, 0, 1'b1);

        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        @(posedge CL_clk);
        @(negedge CL_clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort busy", 32'(busy), 32'h0);
        chk("start+abort pulse_cnt", 32'(pulse_cnt), 32'(last_pc));
        @(posedge CL_clk);
        @(negedge CL_clk);
        chk("start+abort busy later", 32'(busy), 32'h0);

        // Continuous stopped by dropping enable
        run_seq(2, 1, 3, 0, 1'b1, 1'b1, 3'b110, 9, 1'b1, 0, 0, 1'b0);

        // Randomized sequences
        for (int r = 0; r < 14; r++) begin
            d = $urandom_range(0, 4);
            w = $urandom_range(0, 4);
            p = $urandom_range(0, 9);
            n = $urandom_range(0, 4);
            mode = (r % 4 == 3);
            W = (w == 0) ? 1 : w;
            P = (p > W) ? p : W + 1;
            N = (n == 0) ? 1 : n;
            end_k = 1 + d + N * P;
            if (mode) ab_k = 2 + $urandom_range(0, 15);
            else if (r % 3 == 1) ab_k = $urandom_range(2, end_k);
            else ab_k = 0;
            run_seq(d, w, p, n, mode, 1'($urandom), 3'($urandom), ab_k, 1'($urandom),
                    $urandom_range(1, end_k), $urandom_range(1, end_k), 1'(r % 2));
        end

        // Asynchronous reset mid-burst
        cfg_delay  = 24'd1;
        cfg_width  = 24'd3;
        cfg_period = 24'd6;
        cfg_count  = 16'd5;
        cfg_mode   = 1'b0;
        cfg_polarity  = 1'b0;
        cfg_cc_static = 3'b111;
        start = 1'b1;
        @(posedge CL_clk);
        @(negedge CL_clk);
        start = 1'b0;
        repeat (4) @(negedge CL_clk);
        chk("pre-areset busy", 32'(busy), 32'h1);
        #2 CL_CC_aresetn = 1'b0;
        #1;
        chk("areset cc", 32'(CL_CC), 32'h0);
        chk("areset busy", 32'(busy), 32'h0);
        chk("areset pulse_cnt", 32'(pulse_cnt), 32'h0);
        @(negedge CL_clk);
        CL_CC_aresetn = 1'b1;
        repeat (3) @(negedge CL_clk);
        chk("after areset busy", 32'(busy), 32'h0);
        chk("after areset cc", 32'(CL_CC), 32'he);
        chk("after areset done", 32'(done), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
